// File: rtl/load_store_unit_pkg.sv
// Shared core definitions for the load/store path: RV32I funct3 width codes,
// LSU state encodings, the memory word-access code and the access-legality check.
// Latency: n/a (package). Backpressure: n/a.
package load_store_unit_pkg;

    // RV32I load/store width codes (funct3)
    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    // The memory port only ever sees whole-word accesses
    localparam logic [2:0] MEM_WORD = 3'b010;

    // LSU FSM state encodings
    typedef logic [1:0] lsu_state_t;
    localparam lsu_state_t ST_IDLE  = 2'd0;
    localparam lsu_state_t ST_READ  = 2'd1;
    localparam lsu_state_t ST_WRITE = 2'd2;
    localparam lsu_state_t ST_RESP  = 2'd3;

    // 1 when the request must be rejected without touching memory:
    // halfwords need addr[0]=0, words need addr[1:0]=0, stores only have
    // codes 000..010, loads have no 011/110/111.
    function automatic logic lsu_access_err(input logic       store,
                                            input logic [2:0] funct3,
                                            input logic [1:0] addr_lo);
        logic err;
        err = 1'b0;
        case (funct3)
            F3_B:    err = 1'b0;
            F3_H:    err = addr_lo[0];
            F3_W:    err = |addr_lo;
            F3_BU:   err = store;
            F3_HU:   err = store | addr_lo[0];
            default: err = 1'b1;
        endcase
        return err;
    endfunction

endpackage

// File: rtl/lsu_lane.sv
// Byte-lane steering: extracts/extends load data and merges sub-word store data.
// Latency: purely combinational. Backpressure: none.
// Ports: funct3/addr_lo select the lane, mem_word is the memory word,
//        wdata the store data; load_data is the extended result, store_word the merged word.
module lsu_lane (
    input  logic [2:0]  funct3,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] mem_word,
    input  logic [31:0] wdata,
    output logic [31:0] load_data,
    output logic [31:0] store_word
);
    import load_store_unit_pkg::*;

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        byte_sel = mem_word[7:0];
        case (addr_lo)
            2'd0:    byte_sel = mem_word[7:0];
            2'd1:    byte_sel = mem_word[15:8];
            2'd2:    byte_sel = mem_word[23:16];
            default: byte_sel = mem_word[31:24];
        endcase
        half_sel = addr_lo[1] ? mem_word[31:16] : mem_word[15:0];
    end

    always_comb begin
        load_data = mem_word;
        case (funct3)
            F3_B:    load_data = {{24{byte_sel[7]}}, byte_sel};
            F3_H:    load_data = {{16{half_sel[15]}}, half_sel};
            F3_BU:   load_data = {24'h0, byte_sel};
            F3_HU:   load_data = {16'h0, half_sel};
            default: load_data = mem_word;
        endcase
    end

    // Word stores pass wdata straight through; sub-word stores patch one lane
    // of the word fetched by the preceding read.
    always_comb begin
        store_word = wdata;
        case (funct3)
            F3_B: begin
                store_word = mem_word;
                case (addr_lo)
                    2'd0:    store_word[7:0]   = wdata[7:0];
                    2'd1:    store_word[15:8]  = wdata[7:0];
                    2'd2:    store_word[23:16] = wdata[7:0];
                    default: store_word[31:24] = wdata[7:0];
                endcase
            end
            F3_H: begin
                store_word = mem_word;
                if (addr_lo[1]) store_word[31:16] = wdata[15:0];
                else            store_word[15:0]  = wdata[15:0];
            end
            default: store_word = wdata;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// Multicycle load/store unit: word-aligned memory accesses, RMW for sub-word stores.
// Latency (MEM_LATENCY=1): error 1, SW 2, load 3, SB/SH 4 cycles; +MEM_LATENCY-1 per read.
// Backpressure: one request at a time; req_ready is low from accept until the response strobe.
// Ports: req_* request handshake, rsp_* one-cycle response, mem_* word-wide memory data port.
module load_store_unit #(
    parameter int MEM_LATENCY = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_store,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        rsp_misaligned,
    output logic [31:0] mem_address,
    output logic [2:0]  mem_funct3,
    output logic        mem_wren,
    output logic [31:0] mem_data_in,
    input  logic [31:0] mem_data_out
);
    import load_store_unit_pkg::*;

    // READ lasts MEM_LATENCY+1 cycles; the counter runs 0..MEM_LATENCY
    localparam logic [2:0] READ_LAST = 3'(MEM_LATENCY);

    lsu_state_t  state;
    logic        store_q;
    logic [2:0]  funct3_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic [31:0] word_q;
    logic [2:0]  cnt_q;

    logic [31:0] lane_word;
    logic [31:0] load_data;
    logic [31:0] store_word;
    logic        acc_err;

    assign acc_err = lsu_access_err(req_store, req_funct3, req_addr[1:0]);

    // Loads extract from the word arriving on the final READ edge; store
    // merges work on the word captured at that edge.
    assign lane_word = (state == ST_WRITE) ? word_q : mem_data_out;

    lsu_lane u_lane (
        .funct3     (funct3_q),
        .addr_lo    (addr_q[1:0]),
        .mem_word   (lane_word),
        .wdata      (wdata_q),
        .load_data  (load_data),
        .store_word (store_word)
    );

    assign req_ready   = (state == ST_IDLE);
    assign rsp_valid   = (state == ST_RESP);
    assign mem_funct3  = MEM_WORD;
    assign mem_address = (state == ST_READ || state == ST_WRITE) ? {addr_q[31:2], 2'b00} : 32'h0;
    // Gated by reset directly so a reset landing in WRITE never commits the write
    assign mem_wren    = (state == ST_WRITE) && !reset;
    assign mem_data_in = (state == ST_WRITE) ? store_word : 32'h0;

    always_ff @(posedge clk) begin
        if (reset) begin
            state          <= ST_IDLE;
            store_q        <= 1'b0;
            funct3_q       <= 3'b0;
            addr_q         <= 32'h0;
            wdata_q        <= 32'h0;
            word_q         <= 32'h0;
            cnt_q          <= 3'd0;
            rsp_rdata      <= 32'h0;
            rsp_misaligned <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (req_valid) begin
                        store_q  <= req_store;
                        funct3_q <= req_funct3;
                        addr_q   <= req_addr;
                        wdata_q  <= req_wdata;
                        cnt_q    <= 3'd0;
                        if (acc_err) begin
                            state          <= ST_RESP;
                            rsp_rdata      <= 32'h0;
                            rsp_misaligned <= 1'b1;
                        end else if (req_store && req_funct3 == F3_W) begin
                            state <= ST_WRITE;
                        end else begin
                            state <= ST_READ;
                        end
                    end
                end
                ST_READ: begin
                    if (cnt_q == READ_LAST) begin
                        word_q <= mem_data_out;
                        if (store_q) begin
                            state <= ST_WRITE;
                        end else begin
                            state          <= ST_RESP;
                            rsp_rdata      <= load_data;
                            rsp_misaligned <= 1'b0;
                        end
                    end else begin
                        cnt_q <= cnt_q + 3'd1;
                    end
                end
                ST_WRITE: begin
                    state          <= ST_RESP;
                    rsp_rdata      <= 32'h0;
                    rsp_misaligned <= 1'b0;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
module tb_load_store_unit;

    typedef struct packed {
        logic [31:0] rdata;
        logic        mis;
        logic [7:0]  lat;
    } rsp_t;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] data;
    } wr_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset;
    logic        req_valid;
    logic        req_store;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        sel;       // 0: MEM_LATENCY=1 unit, 1: MEM_LATENCY=3 unit
    logic [31:0] mem_rd;

    logic        d1_req_ready, d1_rsp_valid, d1_rsp_mis, d1_mem_wren;
    logic [31:0] d1_rsp_rdata, d1_mem_address, d1_mem_data_in;
    logic [2:0]  d1_mem_funct3;
    logic        d3_req_ready, d3_rsp_valid, d3_rsp_mis, d3_mem_wren;
    logic [31:0] d3_rsp_rdata, d3_mem_address, d3_mem_data_in;
    logic [2:0]  d3_mem_funct3;

    load_store_unit #(.MEM_LATENCY(1)) u_dut1 (
        .clk(clk), .reset(reset),
        .req_valid(req_valid & ~sel), .req_ready(d1_req_ready),
        .req_store(req_store), .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(d1_rsp_valid), .rsp_rdata(d1_rsp_rdata), .rsp_misaligned(d1_rsp_mis),
        .mem_address(d1_mem_address), .mem_funct3(d1_mem_funct3), .mem_wren(d1_mem_wren),
        .mem_data_in(d1_mem_data_in), .mem_data_out(mem_rd)
    );

    load_store_unit #(.MEM_LATENCY(3)) u_dut3 (
        .clk(clk), .reset(reset),
        .req_valid(req_valid & sel), .req_ready(d3_req_ready),
        .req_store(req_store), .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(d3_rsp_valid), .rsp_rdata(d3_rsp_rdata), .rsp_misaligned(d3_rsp_mis),
        .mem_address(d3_mem_address), .mem_funct3(d3_mem_funct3), .mem_wren(d3_mem_wren),
        .mem_data_in(d3_mem_data_in), .mem_data_out(mem_rd)
    );

    // Signals of whichever unit is currently under test
    logic        m_req_ready, m_rsp_valid, m_rsp_mis, m_mem_wren;
    logic [31:0] m_rsp_rdata, m_mem_address, m_mem_data_in;
    logic [2:0]  m_mem_funct3;
    assign m_req_ready   = sel ? d3_req_ready   : d1_req_ready;
    assign m_rsp_valid   = sel ? d3_rsp_valid   : d1_rsp_valid;
    assign m_rsp_mis     = sel ? d3_rsp_mis     : d1_rsp_mis;
    assign m_rsp_rdata   = sel ? d3_rsp_rdata   : d1_rsp_rdata;
    assign m_mem_wren    = sel ? d3_mem_wren    : d1_mem_wren;
    assign m_mem_address = sel ? d3_mem_address : d1_mem_address;
    assign m_mem_data_in = sel ? d3_mem_data_in : d1_mem_data_in;
    assign m_mem_funct3  = sel ? d3_mem_funct3  : d1_mem_funct3;

    // Memory model: 16 words, synchronous read with a 1- or 3-stage pipeline
    logic [31:0] mem [0:15] = '{0: 32'h80F1_22A3, default: 32'h0};
    logic [31:0] pipe [0:2];
    always @(posedge clk) begin
        if (m_mem_wren) mem[m_mem_address[5:2]] <= m_mem_data_in;
        pipe[0] <= mem[m_mem_address[5:2]];
        pipe[1] <= pipe[0];
        pipe[2] <= pipe[1];
    end
    assign mem_rd = sel ? pipe[2] : pipe[0];

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    rsp_t rq[$];
    wr_t  wq[$];
    int   checks = 0;
    int   failures = 0;
    int   tmo_cnt = 0;
    logic quiet = 1'b0;
    logic end_req = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor / scoreboard
    initial begin : monitor
        logic prev_rst, busy, after_rsp, end_done;
        int   acc_cyc;
        rsp_t r;
        wr_t  w;
        prev_rst = 1'b0; busy = 1'b0; after_rsp = 1'b0; end_done = 1'b0; acc_cyc = 0;
        forever begin
            @(negedge clk);
            if (reset) begin
                chk("wren_gated_in_reset", 32'(m_mem_wren), 32'd0);
                if (prev_rst) begin
                    chk("rst_req_ready", 32'(m_req_ready), 32'd1);
                    chk("rst_rsp_valid", 32'(m_rsp_valid), 32'd0);
                    chk("rst_rsp_rdata", m_rsp_rdata, 32'd0);
                    chk("rst_rsp_mis", 32'(m_rsp_mis), 32'd0);
                    chk("rst_mem_address", m_mem_address, 32'd0);
                    chk("rst_mem_data_in", m_mem_data_in, 32'd0);
                end
                busy = 1'b0; after_rsp = 1'b0; prev_rst = 1'b1;
            end else begin
                if (prev_rst) begin
                    chk("idle_after_reset", 32'(m_req_ready), 32'd1);
                    chk("no_rsp_after_reset", 32'(m_rsp_valid), 32'd0);
                end
                prev_rst = 1'b0;
                if (quiet) begin
                    chk("err_no_wren", 32'(m_mem_wren), 32'd0);
                    chk("err_addr_zero", m_mem_address, 32'd0);
                end
                if (m_mem_wren) begin
                    chk("mem_funct3", 32'(m_mem_funct3), 32'd2);
                    if (wq.size() == 0) begin
                        chk("unexpected_write", 32'd1, 32'd0);
                    end else begin
                        w = wq.pop_front();
                        chk("write_addr", m_mem_address, w.addr);
                        chk("write_data", m_mem_data_in, w.data);
                    end
                end
                if (m_rsp_valid) begin
                    chk("ready_low_in_resp", 32'(m_req_ready), 32'd0);
                    if (rq.size() == 0) begin
                        chk("unexpected_rsp", 32'd1, 32'd0);
                    end else begin
                        r = rq.pop_front();
                        chk("rsp_rdata", m_rsp_rdata, r.rdata);
                        chk("rsp_misaligned", 32'(m_rsp_mis), 32'(r.mis));
                        chk("rsp_latency", 32'(cyc + 1 - acc_cyc), 32'(r.lat));
                    end
                    busy = 1'b0; after_rsp = 1'b1;
                end else if (busy) begin
                    chk("ready_low_busy", 32'(m_req_ready), 32'd0);
                end else if (after_rsp) begin
                    chk("ready_after_rsp", 32'(m_req_ready), 32'd1);
                    after_rsp = 1'b0;
                end
                if (req_valid && m_req_ready) begin
                    acc_cyc = cyc + 1;
                    busy = 1'b1;
                end
            end
            if (end_req && !end_done) begin
                chk("rsp_queue_empty", 32'(rq.size()), 32'd0);
                chk("write_queue_empty", 32'(wq.size()), 32'd0);
                chk("driver_timeouts", 32'(tmo_cnt), 32'd0);
                end_done = 1'b1;
            end
        end
    end

    task automatic present(input logic st, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] wd,
                           input logic hold);
        int n;
        req_store = st; req_funct3 = f3; req_addr = a; req_wdata = wd; req_valid = 1'b1;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!m_req_ready && n < 100);
        if (!m_req_ready) tmo_cnt++;
        @(posedge clk); #1;
        if (!hold) req_valid = 1'b0;
    endtask

    task automatic issue(input logic st, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] wd,
                         input logic [31:0] er, input logic em, input int el, input logic hold);
        rsp_t r;
        r.rdata = er; r.mis = em; r.lat = 8'(el);
        rq.push_back(r);
        present(st, f3, a, wd, hold);
    endtask

    task automatic expect_write(input logic [31:0] a, input logic [31:0] d);
        wr_t w;
        w.addr = a; w.data = d;
        wq.push_back(w);
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while ((rq.size() != 0 || !m_req_ready) && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) tmo_cnt++;
        repeat (2) @(posedge clk);
        #1;
    endtask

    // SB accepted, then reset pulsed during its single WRITE cycle
    task automatic reset_in_write(input logic [31:0] a, input logic [31:0] wd, input int reads);
        present(1'b1, 3'b000, a, wd, 1'b0);
        repeat (reads) begin
            @(posedge clk); #1;
        end
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
    endtask

    initial begin
        reset = 1'b1; req_valid = 1'b0; req_store = 1'b0; req_funct3 = 3'b0;
        req_addr = 32'h0; req_wdata = 32'h0; sel = 1'b0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;

        // Loads from 0x2000 = 0x80F1_22A3
        issue(1'b0, 3'b000, 32'h2003, 32'h0, 32'hFFFF_FF80, 1'b0, 3, 1'b0);
        issue(1'b0, 3'b100, 32'h2000, 32'h0, 32'h0000_00A3, 1'b0, 3, 1'b0);
        issue(1'b0, 3'b001, 32'h2002, 32'h0, 32'hFFFF_80F1, 1'b0, 3, 1'b0);
        issue(1'b0, 3'b101, 32'h2000, 32'h0, 32'h0000_22A3, 1'b0, 3, 1'b0);
        issue(1'b0, 3'b010, 32'h2000, 32'h0, 32'h80F1_22A3, 1'b0, 3, 1'b0);

        // Stores
        expect_write(32'h2000, 32'h80F1_55A3);
        issue(1'b1, 3'b000, 32'h2001, 32'h0000_0055, 32'h0, 1'b0, 4, 1'b0);
        issue(1'b0, 3'b010, 32'h2000, 32'h0, 32'h80F1_55A3, 1'b0, 3, 1'b0);
        expect_write(32'h2004, 32'hDEAD_BEEF);
        issue(1'b1, 3'b010, 32'h2004, 32'hDEAD_BEEF, 32'h0, 1'b0, 2, 1'b0);
        expect_write(32'h2004, 32'h1234_BEEF);
        issue(1'b1, 3'b001, 32'h2006, 32'hAAAA_1234, 32'h0, 1'b0, 4, 1'b0);

        // Rejected accesses never reach memory
        wait_idle();
        quiet = 1'b1;
        issue(1'b0, 3'b010, 32'h2002, 32'h0, 32'h0, 1'b1, 1, 1'b0);
        issue(1'b1, 3'b001, 32'h2001, 32'h0000_FFFF, 32'h0, 1'b1, 1, 1'b0);
        issue(1'b0, 3'b011, 32'h2000, 32'h0, 32'h0, 1'b1, 1, 1'b0);
        issue(1'b1, 3'b100, 32'h2000, 32'h0, 32'h0, 1'b1, 1, 1'b0);
        wait_idle();
        quiet = 1'b0;

        // req_valid held across a busy load, then a second request
        issue(1'b0, 3'b010, 32'h2004, 32'h0, 32'h1234_BEEF, 1'b0, 3, 1'b1);
        issue(1'b0, 3'b000, 32'h2004, 32'h0, 32'hFFFF_FFEF, 1'b0, 3, 1'b0);

        // Reset during the WRITE of an SB: memory must be untouched
        wait_idle();
        reset_in_write(32'h2000, 32'h0000_00CC, 2);
        repeat (2) @(posedge clk);
        #1;
        issue(1'b0, 3'b010, 32'h2000, 32'h0, 32'h80F1_55A3, 1'b0, 3, 1'b0);

        // Same checks on the MEM_LATENCY=3 unit
        wait_idle();
        sel = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        issue(1'b0, 3'b010, 32'h2004, 32'h0, 32'h1234_BEEF, 1'b0, 5, 1'b0);
        expect_write(32'h2004, 32'h7734_BEEF);
        issue(1'b1, 3'b000, 32'h2007, 32'h0000_0077, 32'h0, 1'b0, 6, 1'b0);
        issue(1'b0, 3'b101, 32'h2006, 32'h0, 32'h0000_7734, 1'b0, 5, 1'b0);
        wait_idle();
        reset_in_write(32'h2004, 32'h0000_0011, 4);
        repeat (2) @(posedge clk);
        #1;
        issue(1'b0, 3'b010, 32'h2004, 32'h0, 32'h7734_BEEF, 1'b0, 5, 1'b0);
        wait_idle();

        end_req = 1'b1;
        repeat (3) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
Multicycle load/store unit between the core datapath/control FSM and the data port of the unified memory. It accepts one request per handshake and issues only word-aligned word accesses to memory. Sub-word stores are done as read-modify-write. Load data is extracted from the correct byte lane and sign- or zero-extended before being returned to the datapath, and misaligned or illegal accesses are flagged without touching memory.

Parameters:
MEM_LATENCY, 1, cycles from mem_address presented to mem_data_out valid (synchronous read); legal range 1-4

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
req_valid  in  1  request present
req_ready  out  1  unit idle, request accepted when valid&&ready at posedge
req_store  in  1  1=store, 0=load
req_funct3  in  3  RV32I width/sign code (LB 000, LH 001, LW 010, LBU 100, LHU 101; SB 000, SH 001, SW 010)
req_addr  in  32  byte address
req_wdata  in  32  store data (low bits used for SB/SH)
rsp_valid  out  1  one-cycle response strobe
rsp_rdata  out  32  extended load data; 0 for stores and errors
rsp_misaligned  out  1  access rejected (misaligned or illegal funct3), valid with rsp_valid
mem_address  out  32  word address {addr[31:2],2'b00}
mem_funct3  out  3  constant 3'b010 (word access)
mem_wren  out  1  memory write enable
mem_data_in  out  32  write data word
mem_data_out  in  32  read data word

Behaviour:
- Reset values: req_ready=1 (IDLE), rsp_valid=0, rsp_rdata=0, rsp_misaligned=0, mem_wren=0, mem_address=0, mem_data_in=0.
- States: IDLE, READ, WRITE, RESP.
- IDLE: req_ready=1. On accept, latch store/funct3/addr/wdata.
  - Error condition: LH/LHU/SH with addr[0]=1; LW/SW with addr[1:0]!=0; load funct3 011/110/111; store funct3 >010. Error goes to RESP with misaligned=1 and no memory access.
  - Otherwise: a load or sub-word store goes to READ; SW goes to WRITE.
- READ: mem_address held for MEM_LATENCY+1 cycles (internal counter). mem_data_out is captured at the final READ edge. A load then goes to RESP; a sub-word store goes to WRITE.
- WRITE: exactly one cycle with mem_wren=1.
  - SW: mem_data_in=wdata.
  - SB: captured word with byte lane addr[1:0] replaced by wdata[7:0].
  - SH: half lane addr[1] replaced by wdata[15:0].
  - Then go to RESP.
- RESP: rsp_valid=1 for exactly one cycle, req_ready=0, then IDLE.
  - rsp_rdata and rsp_misaligned are registered and held until the next RESP.
- Load extraction is little-endian. LB/LH sign-extend from bit 7/15; LBU/LHU zero-extend.
- Latency from accept edge to rsp_valid (MEM_LATENCY=1): error 1 cycle; SW 2; load 3; SB/SH 4. Each READ adds MEM_LATENCY-1 cycles beyond that.
- req_valid while busy is ignored (req_ready=0). Requests are never queued.
- mem_wren is gated combinationally by ~reset, so reset asserted during WRITE suppresses the write.
- Reset mid-operation aborts to IDLE with no rsp_valid.
- mem_address is 0 in IDLE.

Decomposition:
- Shared package (core-wide): funct3 load/store encodings, LSU state enum, MEM_WORD constant 3'b010.
- One sub-module, lsu_lane: combinational extract/extend for loads and merge for stores, keyed on funct3 and addr[1:0].
- The FSM and registers stay in load_store_unit.

Test Plan:
- Memory word 0x80F1_22A3 at 0x2000. LB at 0x2003 -> rsp_rdata=0xFFFF_FF80; LBU at 0x2000 -> 0x0000_00A3; LH at 0x2002 -> 0xFFFF_80F1; LW at 0x2000 -> 0x80F1_22A3, rsp_valid exactly 3 cycles after accept.
- SB 0x55 to 0x2001 over 0x80F1_22A3 -> a single mem_wren cycle writing 0x80F1_55A3; a following LW returns 0x80F1_55A3; response 4 cycles after accept.
- SW 0xDEAD_BEEF to 0x2004 -> one write cycle, rsp_valid at cycle 2, rsp_rdata=0, rsp_misaligned=0.
- LW at 0x2002; SH at 0x2001; load funct3 011 -> rsp_misaligned=1 at cycle 1; mem_wren stays 0 and mem_address stays 0 throughout.
- req_valid held high during a load -> req_ready low for 3 cycles; second request accepted only on the cycle after rsp_valid; back-to-back responses are correct.
- Reset asserted during WRITE of SB -> mem_wren=0 that cycle, memory unchanged, unit in IDLE next cycle, no rsp_valid; repeat with MEM_LATENCY=3 and check load latency of 5.
